nx_fifo_prefetch_rd: RTL and testbench
======================================

// Module: nx_fifo_prefetch_rd
// PURPOSE
//  Read-side prefetch stage directly downstream of nx_fifo_ctrl. Drives the controller's ren,
//  captures data from the FIFO RAM after a fixed read latency, and holds it in a small output
//  buffer. Presents a valid/ready stream whose data sits in registers, not RAM.
//  Never issues a read that could cause underflow or overrun its own buffer.
// PARAMETERS
//  DATA_W     32  width of the RAM read data and of rd_data
//  RD_LAT     1   cycles from fifo_ren to ram_rdata valid (1..3)
//  OUT_DEPTH  3   output buffer entries; must be >= RD_LAT+2 for 1 word/cycle
// PORTS
//  clk        in   1        clock; all logic on the rising edge
//  rst        in   1        reset: asynchronous, active-high
//  clear      in   1        sync flush; the same signal drives nx_fifo_ctrl.clear
//  fifo_empty in   1        empty from nx_fifo_ctrl
//  fifo_ren   out  1        ren to nx_fifo_ctrl; the RAM read address is ctrl rptr
//  ram_rdata  in   DATA_W   RAM read data, valid RD_LAT cycles after fifo_ren
//  rd_valid   out  1        rd_data holds a word
//  rd_ready   in   1        consumer accepts; transfer when rd_valid & rd_ready
//  rd_data    out  DATA_W   head of the output buffer
//  stall_cnt  out  16       present only with NX_FIFO_PREFETCH_STATS_EN
// BEHAVIOUR
//  - Reset state: occ=0, in-flight pipe=0, rd_valid=0, rd_data=0, stall_cnt=0.
//    fifo_ren is forced 0 while rst is high.
//  - Credit rule: fifo_ren = !rst & !clear & !fifo_empty & (occ + inflight < OUT_DEPTH).
//    inflight = popcount of the RD_LAT-deep valid shift pipe. A pop in the current cycle
//    earns no credit until the next cycle, which keeps the path registered.
//  - Write: when pipe[RD_LAT-1] is set in cycle t, ram_rdata is written into the buffer at
//    the end of cycle t. rd_valid is high from t+1.
//  - First-word latency: fifo_ren at cycle t gives rd_valid at t+RD_LAT+1.
//  - Buffer is a circular array: wr_ptr/rd_ptr wrap at OUT_DEPTH (not a power of 2).
//    occ has width $clog2(OUT_DEPTH+1).
//  - Push and pop in the same cycle: occ is unchanged and both pointers advance. When the
//    buffer is full the credit rule already blocks pushes, so a write into a full buffer is
//    an assertion error.
//  - rd_valid = (occ != 0). rd_data is stable while rd_valid & !rd_ready (AXI-style hold).
//  - clear (1 cycle): occ, pointers and the in-flight pipe are zeroed at the clock edge.
//    rd_valid=0 the next cycle. Data returning from reads issued before clear is discarded.
//  - rst mid-operation: all state goes to reset values asynchronously. Release is
//    synchronous to clk through the standard reset synchroniser upstream.
//  - Because fifo_ren never fires when fifo_empty=1, the ctrl underflow output must stay 0.
// CONFIGURATION
//  - With NX_FIFO_PREFETCH_STATS_EN defined: port stall_cnt exists. It is a 16-bit counter
//    that increments each cycle rd_valid & !rd_ready, saturates at 16'hFFFF, and is zeroed
//    by rst or clear.
//  - Without the macro: the port and counter are absent, and all other behaviour is identical.
// STRUCTURE
//  - Package nx_fifo_prefetch_pkg holds:
//    - function occ_w(depth) = $clog2(depth+1)
//    - localparam STALL_CNT_W = 16
//    - typedef for the in-flight pipe vector
//  - Sub-module nx_fifo_prefetch_buf: OUT_DEPTH x DATA_W register array with wr/rd pointers
//    and occ. The top level keeps the credit logic, the in-flight pipe and the stats counter.
// TESTING
//  1. One word written to ctrl; fifo_empty falls at cycle t -> fifo_ren=1 at t only;
//     rd_valid=1 at t+2 with rd_data=0xA5A5_0001.
//  2. rd_ready=0, 5 words queued -> exactly 3 fifo_ren pulses, then fifo_ren=0 held.
//     Raise rd_ready -> 5 words out in order, no bubbles after the first.
//  3. 16 words queued, rd_ready=1 -> rd_valid high on 16 consecutive cycles.
//     fifo_ren sustains 1/cycle.
//  4. clear with 2 words buffered and 1 read in flight -> rd_valid=0 the next cycle.
//     The returning word is dropped; the next pushed word 0x1234 is the first output.
//  5. rst asserted mid-stream, asynchronously between edges -> rd_valid, fifo_ren and
//     rd_data go to 0 before the next edge.
//  6. STATS_EN: valid held with rd_ready=0 for 10 cycles -> stall_cnt=10. Preload near
//     16'hFFFF -> stays at 16'hFFFF.

Source files
------------

// File: rtl/nx_fifo_prefetch_pkg.sv
// Shared types and sizing helpers for the nx_fifo prefetch read stage.
`timescale 1ns/1ps
package nx_fifo_prefetch_pkg;

  localparam int STALL_CNT_W = 16;
  localparam int MAX_RD_LAT  = 3;

  // Bits above RD_LAT-1 are held at zero by the top level.
  typedef logic [MAX_RD_LAT-1:0] inflight_pipe_t;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nx_fifo_prefetch_buf.sv
// Circular output buffer of the prefetch stage: DEPTH x DATA_W registers, wr/rd pointers, occupancy.
`timescale 1ns/1ps
module nx_fifo_prefetch_buf
  import nx_fifo_prefetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head,
  output logic [occ_w(DEPTH)-1:0] occ
);

  localparam int OCC_W = occ_w(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign head = mem[rd_ptr];

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  a_no_write_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !clear && occ == FULL));

endmodule

// File: rtl/nx_fifo_prefetch_rd.sv
// Read-side prefetch stage behind nx_fifo_ctrl: credit-based ren, RD_LAT in-flight pipe, registered output.
// Optional stall counter port enabled by NX_FIFO_PREFETCH_STATS_EN.
`timescale 1ns/1ps
module nx_fifo_prefetch_rd
  import nx_fifo_prefetch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int OUT_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   fifo_empty,
  output logic                   fifo_ren,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic                   rd_valid,
  input  logic                   rd_ready,
`ifdef NX_FIFO_PREFETCH_STATS_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  output logic [DATA_W-1:0]      rd_data
);

  localparam int OCC_W = occ_w(OUT_DEPTH);
  localparam int CMT_W = OCC_W + 1;
  localparam inflight_pipe_t PIPE_MASK = inflight_pipe_t'((1 << RD_LAT) - 1);

  inflight_pipe_t   pipe;
  logic [OCC_W-1:0] occ;
  logic [CMT_W-1:0] committed;
  logic             push;
  logic             pop;

  // Credit uses registered occ only: a pop frees a slot from the next cycle on.
  assign committed = {1'b0, occ} + CMT_W'($countones(pipe));
  assign fifo_ren  = !rst && !clear && !fifo_empty && (committed < CMT_W'(OUT_DEPTH));
  assign push      = pipe[RD_LAT-1];
  assign rd_valid  = (occ != '0);
  assign pop       = rd_valid && rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pipe <= '0;
    else if (clear) pipe <= '0;
    else            pipe <= {pipe[MAX_RD_LAT-2:0], fifo_ren} & PIPE_MASK;
  end

  nx_fifo_prefetch_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .push    (push),
    .wr_data (ram_rdata),
    .pop     (pop),
    .head    (rd_data),
    .occ     (occ)
  );

`ifdef NX_FIFO_PREFETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          stall_cnt <= '0;
    else if (clear)                                   stall_cnt <= '0;
    else if (rd_valid && !rd_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_nx_fifo_prefetch_rd.sv
// Scoreboard bench for nx_fifo_prefetch_rd with a behavioural nx_fifo_ctrl + 1-cycle RAM model.
`timescale 1ns/1ps
module tb_nx_fifo_prefetch_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        fifo_empty;
  logic        fifo_ren;
  logic [31:0] ram_rdata = '0;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
`ifdef NX_FIFO_PREFETCH_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram_q[$];
  int          ram_wr    = 0;
  int          rd_idx    = 0;
  int          flush_idx = 0;
  int          hd;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  nx_fifo_prefetch_rd #(
    .DATA_W    (32),
    .RD_LAT    (1),
    .OUT_DEPTH (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .ram_rdata  (ram_rdata),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
`ifdef NX_FIFO_PREFETCH_STATS_EN
    .stall_cnt  (stall_cnt),
`endif
    .rd_data    (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ctrl + RAM model: head index advances by NBA so fifo_empty changes after the DUT samples it
  assign hd         = (rd_idx > flush_idx) ? rd_idx : flush_idx;
  assign fifo_empty = (hd >= ram_wr);

  always @(posedge clk) begin
    if (!rst && fifo_ren) begin
      check("no_underflow", 32'(hd < ram_wr), 32'd1);
      if (hd < ram_wr) ram_rdata <= ram_q[hd];
      rd_idx <= hd + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("stream_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    ram_q.push_back(w);
    ram_wr = ram_wr + 1;
    exp_q.push_back(w);
  endtask

  task automatic flush_all();
    flush_idx = ram_wr;
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int n_ren;
    int ren_run, ren_best, v_run, v_best;
    rst = 1'b1; clear = 1'b0; rd_ready = 1'b0;
    #12;
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data",  rd_data,       32'd0);
    check("rst_ren",   32'(fifo_ren), 32'd0);
    @(negedge clk); #1 rst = 1'b0;

    // 1: single word, ren for one cycle, valid two cycles later
    tick();
    rd_ready = 1'b1;
    push_word(32'hA5A5_0001);
    @(negedge clk); check("t1_ren_t", 32'(fifo_ren), 32'd1);
    check("t1_valid_t", 32'(rd_valid), 32'd0);
    tick(); @(negedge clk);
    check("t1_ren_t1", 32'(fifo_ren), 32'd0);
    check("t1_valid_t1", 32'(rd_valid), 32'd0);
    tick(); @(negedge clk);
    check("t1_valid_t2", 32'(rd_valid), 32'd1);
    check("t1_data_t2", rd_data, 32'hA5A5_0001);
    repeat (3) tick();

    // 2: back-pressure limits reads to the buffer depth, then drains without bubbles
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h2000_0000 + 32'(i));
    n_ren = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_ren) n_ren++;
    end
    check("t2_ren_pulses", 32'(n_ren), 32'd3);
    check("t2_ren_held", 32'(fifo_ren), 32'd0);
    tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_no_bubble", 32'(rd_valid), 32'd1);
    end
    @(negedge clk); check("t2_empty_after", 32'(rd_valid), 32'd0);
    tick();

    // 3: streaming at one word per cycle
    for (int i = 0; i < 16; i++) push_word(32'h3000_0000 + 32'(i * 7));
    ren_run = 0; ren_best = 0; v_run = 0; v_best = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      ren_run = fifo_ren ? ren_run + 1 : 0;
      v_run   = rd_valid ? v_run + 1 : 0;
      if (ren_run > ren_best) ren_best = ren_run;
      if (v_run > v_best) v_best = v_run;
    end
    check("t3_ren_run", 32'(ren_best), 32'd16);
    check("t3_valid_run", 32'(v_best), 32'd16);
    tick();
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: clear with two buffered and one in flight
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h4000_0001 + 32'(i));
    repeat (3) tick();
    check("t4_pre_valid", 32'(rd_valid), 32'd1);
    clear = 1'b1;
    flush_all();
    tick();
    clear = 1'b0;
    @(negedge clk); check("t4_valid_after_clear", 32'(rd_valid), 32'd0);
    tick();
    @(negedge clk); check("t4_inflight_dropped", 32'(rd_valid), 32'd0);
    tick();
    rd_ready = 1'b1;
    push_word(32'h0000_1234);
    repeat (2) tick();
    @(negedge clk);
    check("t4_first_valid", 32'(rd_valid), 32'd1);
    check("t4_first_data", rd_data, 32'h0000_1234);
    repeat (2) tick();

`ifdef NX_FIFO_PREFETCH_STATS_EN
    // 6: stall counter counts held-valid cycles and saturates
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rd_ready = 1'b0;
    push_word(32'h6000_0001);
    repeat (12) tick();
    @(negedge clk); check("t6_stall_10", 32'(stall_cnt), 32'd10);
    repeat (65600) tick();
    @(negedge clk); check("t6_stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
    tick();
    rd_ready = 1'b1;
    repeat (3) tick();
`endif

    // 5: asynchronous reset between edges while streaming
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'h5000_0000 + 32'(i));
    repeat (4) tick();
    #2;
    check("t5_pre_ren", 32'(fifo_ren), 32'd1);
    check("t5_pre_valid", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_rst_valid", 32'(rd_valid), 32'd0);
    check("t5_rst_ren", 32'(fifo_ren), 32'd0);
    check("t5_rst_data", rd_data, 32'd0);
    @(negedge clk);
    flush_all();
    #1 rst = 1'b0;
    repeat (3) tick();
    @(negedge clk); check("t5_idle_after", 32'(rd_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
